// File: rtl/video_src_uhd_4_if.sv
// AXI4-Stream video bus, 4 RGB pixels (96 bits) per beat.
// master: tdata/tvalid/tuser/tlast out, tready in; slave: the reverse.
interface video_src_uhd_4_if;
  logic [95:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/video_src_uhd_4.sv
// AXI4-Stream test-frame source, 4 ppc RGB888, with h/v blanking.
// Ports: m_axis_video_aclk/areset, enable, mode, solid_rgb in;
// VIDEO_IN stream (master), frame_done pulse, frame_cnt out.
module video_src_uhd_4 #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int HBLANK = 4,
  parameter int VBLANK = 16
) (
  input  logic                       m_axis_video_aclk,
  input  logic                       m_axis_video_areset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [23:0]                solid_rgb,
  video_src_uhd_4_if.master          VIDEO_IN,
  output logic                       frame_done,
  output logic [15:0]                frame_cnt
);

  localparam int BEATS = WIDTH / 4;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BLMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int CW    = (BLMAX > 0) ? $clog2(BLMAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t state, state_d;

  logic [BW-1:0] beat, beat_d;
  logic [YW-1:0] y, y_d;
  logic [CW-1:0] bcnt, bcnt_d;
  logic [1:0]    cur_mode, cur_mode_d;
  logic [23:0]   cur_rgb, cur_rgb_d;
  logic [7:0]    cur_f, cur_f_d;
  logic [15:0]   cnt_d;
  logic [95:0]   tdata, tdata_d;
  logic          tuser, tlast;
  logic          done_d;
  logic          load;
  logic          start;
  logic          xfer;
  logic          last_beat;
  logic          last_line;

  function automatic logic [23:0] pix(
    input logic [1:0]  m,
    input logic [23:0] rgb,
    input logic [7:0]  f,
    input logic [7:0]  x,
    input logic [7:0]  yy
  );
    logic [23:0] p;
    p = '0;
    unique case (m)
      2'd0:    p = {x, yy, f};
      2'd1:    p = {24{x[3] ^ yy[3]}};
      2'd2:    p = rgb;
      default: p = {f, f, f};
    endcase
    return p;
  endfunction

  function automatic logic [95:0] beat_data(
    input logic [BW-1:0] b,
    input logic [YW-1:0] yy,
    input logic [1:0]    m,
    input logic [23:0]   rgb,
    input logic [7:0]    f
  );
    logic [95:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      d[95-24*k -: 24] = pix(m, rgb, f,
                             8'({b, 2'b00} + k),
                             8'(yy));
    end
    return d;
  endfunction

  assign xfer      = (state == S_ACTIVE) && VIDEO_IN.tready;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign last_line = (y == YW'(HEIGHT - 1));

  always_comb begin
    state_d    = state;
    beat_d     = beat;
    y_d        = y;
    bcnt_d     = bcnt;
    cur_mode_d = cur_mode;
    cur_rgb_d  = cur_rgb;
    cur_f_d    = cur_f;
    cnt_d      = frame_cnt;
    done_d     = 1'b0;
    load       = 1'b0;
    start      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (enable) start = 1'b1;
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (!last_beat) begin
            beat_d = beat + 1'b1;
            load   = 1'b1;
          end else if (!last_line) begin
            if (HBLANK == 0) begin
              beat_d = '0;
              y_d    = y + 1'b1;
              load   = 1'b1;
            end else begin
              state_d = S_HBLANK;
              bcnt_d  = '0;
            end
          end else begin
            done_d = 1'b1;
            cnt_d  = frame_cnt + 16'd1;
            if (VBLANK == 0) begin
              if (enable) start = 1'b1;
              else        state_d = S_IDLE;
            end else begin
              state_d = S_VBLANK;
              bcnt_d  = '0;
            end
          end
        end
      end
      S_HBLANK: begin
        if (bcnt == CW'(HBLANK - 1)) begin
          state_d = S_ACTIVE;
          beat_d  = '0;
          y_d     = y + 1'b1;
          load    = 1'b1;
        end else begin
          bcnt_d = bcnt + 1'b1;
        end
      end
      S_VBLANK: begin
        if (bcnt == CW'(VBLANK - 1)) begin
          if (enable) start = 1'b1;
          else        state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start latches settings; frame number includes an
    // increment happening on this same edge (VBLANK = 0 case).
    if (start) begin
      state_d    = S_ACTIVE;
      beat_d     = '0;
      y_d        = '0;
      cur_mode_d = mode;
      cur_rgb_d  = solid_rgb;
      cur_f_d    = cnt_d[7:0];
      load       = 1'b1;
    end
  end

  assign tdata_d = beat_data(beat_d, y_d, cur_mode_d,
                             cur_rgb_d, cur_f_d);

  always_ff @(posedge m_axis_video_aclk or posedge m_axis_video_areset) begin
    if (m_axis_video_areset) begin
      state      <= S_IDLE;
      beat       <= '0;
      y          <= '0;
      bcnt       <= '0;
      cur_mode   <= '0;
      cur_rgb    <= '0;
      cur_f      <= '0;
      tdata      <= '0;
      tuser      <= 1'b0;
      tlast      <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_d;
      beat       <= beat_d;
      y          <= y_d;
      bcnt       <= bcnt_d;
      cur_mode   <= cur_mode_d;
      cur_rgb    <= cur_rgb_d;
      cur_f      <= cur_f_d;
      frame_done <= done_d;
      frame_cnt  <= cnt_d;
      if (load) begin
        tdata <= tdata_d;
        tuser <= (beat_d == '0) && (y_d == '0);
        tlast <= (beat_d == BW'(BEATS - 1));
      end
    end
  end

  assign VIDEO_IN.tvalid = (state == S_ACTIVE);
  assign VIDEO_IN.tdata  = tdata;
  assign VIDEO_IN.tuser  = tuser & VIDEO_IN.tvalid;
  assign VIDEO_IN.tlast  = tlast & VIDEO_IN.tvalid;

endmodule

// File: tb/tb_video_src_uhd_4.sv
// Scoreboard bench for video_src_uhd_4: ramp, backpressure,
// random tready, checker/solid/gray, enable drop, mid-frame reset.
module tb_video_src_uhd_4;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int HB = 4;
  localparam int VB = 16;
  localparam int NB = W / 4;

  typedef struct packed {
    logic [95:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic        frame_done;
  logic [15:0] frame_cnt;

  video_src_uhd_4_if vif ();

  video_src_uhd_4 #(
    .WIDTH (W),
    .HEIGHT(H),
    .HBLANK(HB),
    .VBLANK(VB)
  ) dut (
    .m_axis_video_aclk  (clk),
    .m_axis_video_areset(rst),
    .enable             (enable),
    .mode               (mode),
    .solid_rgb          (solid),
    .VIDEO_IN           (vif),
    .frame_done         (frame_done),
    .frame_cnt          (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    sof_n = 0;
  int    sof_prev = 0;
  int    sof_last = 0;
  int    done_n = 0;
  int    beats_n = 0;
  int    fb = 0;
  int    idx;
  logic [95:0] spot0, spot2, spot128;
  logic        hold_pend = 1'b0;
  logic [95:0] hold_d;
  logic        hold_u, hold_l;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] model_beat(
    input int m, input logic [23:0] s,
    input int f, input int b, input int y);
    logic [95:0] d;
    logic [23:0] px;
    int x;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      x = 4 * b + k;
      case (m)
        0: px = {8'(x % 256), 8'(y % 256), 8'(f % 256)};
        1: px = ((((x / 8) % 2) != ((y / 8) % 2))) ?
                24'hFFFFFF : 24'h000000;
        2: px = s;
        default: px = {3{8'(f % 256)}};
      endcase
      d[95-24*k -: 24] = px;
    end
    return d;
  endfunction

  task automatic push_frame(input int m, input logic [23:0] s,
                            input int f);
    beat_t e;
    for (int y = 0; y < H; y++) begin
      for (int b = 0; b < NB; b++) begin
        e.d = model_beat(m, s, f, b, y);
        e.u = (b == 0) && (y == 0);
        e.l = (b == NB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: transfers seen at the negedge complete on the next posedge.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold_pend = 1'b0;
      exp_q.delete();
    end else begin
      if (hold_pend) begin
        check("hold_valid", vif.tvalid, 1);
        check("hold_data", vif.tdata, hold_d);
        check("hold_user", vif.tuser, hold_u);
        check("hold_last", vif.tlast, hold_l);
      end
      if (frame_done) done_n++;
      if (vif.tvalid && vif.tready) begin
        idx = vif.tuser ? 0 : fb;
        if (idx == 0)   spot0   = vif.tdata;
        if (idx == 2)   spot2   = vif.tdata;
        if (idx == 128) spot128 = vif.tdata;
        if (vif.tuser) begin
          sof_n++;
          sof_prev = sof_last;
          sof_last = cyc;
        end
        fb = idx + 1;
        beats_n++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", vif.tdata, e.d);
          check("tuser", vif.tuser, e.u);
          check("tlast", vif.tlast, e.l);
        end
      end
      hold_pend = vif.tvalid && !vif.tready;
      hold_d    = vif.tdata;
      hold_u    = vif.tuser;
      hold_l    = vif.tlast;
    end
  end

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!vif.tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!vif.tvalid) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_sof(input int target);
    int n = 0;
    while (sof_n < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sof_n < target) check("sof_timeout", sof_n, target);
  endtask

  task automatic wait_fb(input int target);
    int n = 0;
    while (fb < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (fb < target) check("fb_timeout", fb, target);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (VB + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int bs, bd, bb, n;
    rst        = 1'b1;
    enable     = 1'b0;
    mode       = 2'd0;
    solid      = '0;
    vif.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", vif.tvalid, 0);
    check("rst_tuser", vif.tuser, 0);
    check("rst_tlast", vif.tlast, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;

    // Two back-to-back ramp frames, full throughput.
    push_frame(0, 24'h0, 0);
    push_frame(0, 24'h0, 1);
    bs = sof_n;
    bd = done_n;
    @(negedge clk);
    enable = 1'b1;
    wait_valid();
    check("first_tdata", vif.tdata,
          96'h000000_010000_020000_030000);
    check("first_tuser", vif.tuser, 1);
    wait_sof(bs + 2);
    enable = 1'b0;
    drain();
    check("sof_gap", sof_last - sof_prev, 1292);
    check("fcnt_t1", frame_cnt, 2);
    check("done_t1", done_n - bd, 2);
    check("idle_t1", vif.tvalid, 0);
    check("sof_t1", sof_n - bs, 2);

    // Stall beat 5 for 3 cycles.
    push_frame(0, 24'h0, 2);
    bs = sof_n;
    bb = beats_n;
    @(negedge clk);
    enable = 1'b1;
    wait_sof(bs + 1);
    enable = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (fb != 5 && n < 200);
    check("stall_pos", fb, 5);
    vif.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vif.tready = 1'b1;
    drain();
    check("bp_beats", beats_n - bb, W * H / 4);
    check("fcnt_t2", frame_cnt, 3);

    // Fresh reset, then two frames under random tready.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(0, 24'h0, 0);
    push_frame(0, 24'h0, 1);
    bs = sof_n;
    bd = done_n;
    bb = beats_n;
    enable = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      #1;
      vif.tready = 1'($urandom_range(0, 1));
      if (sof_n >= bs + 2) enable = 1'b0;
      n++;
    end
    check("rand_left", exp_q.size(), 0);
    vif.tready = 1'b1;
    enable = 1'b0;
    repeat (VB + 4) @(posedge clk);
    #1;
    check("rand_beats", beats_n - bb, 2048);
    check("fcnt_t3", frame_cnt, 2);
    check("done_t3", done_n - bd, 2);

    // Checker, solid, gray; inputs change mid-frame.
    mode = 2'd1;
    push_frame(1, 24'h0, 2);
    bs = sof_n;
    @(negedge clk);
    enable = 1'b1;
    wait_sof(bs + 1);
    mode  = 2'd2;
    solid = 24'h123456;
    push_frame(2, 24'h123456, 3);
    wait_fb(200);
    check("chk_l0b2", spot2, {4{24'hFFFFFF}});
    check("chk_l0b0", spot0, 96'h0);
    check("chk_l8b0", spot128, {4{24'hFFFFFF}});
    wait_sof(bs + 2);
    mode  = 2'd3;
    solid = 24'h0;
    push_frame(3, 24'h0, 4);
    wait_sof(bs + 3);
    enable = 1'b0;
    mode   = 2'd0;
    drain();
    check("fcnt_t4", frame_cnt, 5);

    // enable dropped at line 10.
    push_frame(0, 24'h0, 5);
    bs = sof_n;
    bd = done_n;
    @(negedge clk);
    enable = 1'b1;
    wait_sof(bs + 1);
    wait_fb(10 * NB);
    enable = 1'b0;
    drain();
    check("drop_done", done_n - bd, 1);
    check("drop_idle", vif.tvalid, 0);
    check("drop_sof", sof_n - bs, 1);
    check("fcnt_t5", frame_cnt, 6);

    // Reset in the middle of line 20.
    push_frame(0, 24'h0, 6);
    bs = sof_n;
    @(negedge clk);
    enable = 1'b1;
    wait_sof(bs + 1);
    wait_fb(20 * NB + 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mr_tvalid", vif.tvalid, 0);
    check("mr_tuser", vif.tuser, 0);
    check("mr_tlast", vif.tlast, 0);
    check("mr_fcnt", frame_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(0, 24'h0, 0);
    bs = sof_n;
    wait_valid();
    check("mr_first", vif.tdata,
          96'h000000_010000_020000_030000);
    check("mr_tuser1", vif.tuser, 1);
    wait_sof(bs + 1);
    enable = 1'b0;
    drain();
    check("fcnt_t6", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
